// File: rtl/countdown_pkg.sv
// Shared types and defaults for the parametrised countdown timer and its prescaler.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH    = 7;
  localparam int DEFAULT_PRESCALE = 1;

  // A divide-by-1 prescaler still needs a 1-bit counter to keep the port widths legal.
  function automatic int prescale_cnt_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles down to one tick every PRESCALE cycles.
// clear has priority over enable; a disabled prescaler holds its phase.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = prescale_cnt_width(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer_param.sv
// Parametrised countdown timer with prescaler, pause/resume, abort and auto-reload.
// done is a registered one-cycle pulse that coincides with the post-expiry count value.
module countdown_timer_param
  import countdown_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] preset_value,
  output logic [WIDTH-1:0] count_out,
  output logic             active,
  output logic             done,
  output logic             paused,
  output logic [1:0]       state_dbg
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic             done_q;
  logic             done_d;
  logic             counting;
  logic             presc_clear;
  logic             tick;

  // The cycle that leaves HOLD (pause low) counts, so a pause of N cycles delays expiry by exactly N.
  assign counting    = (state_q != IDLE) && !start && !abort && !pause;
  assign presc_clear = start || abort;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(counting),
    .clear (presc_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (start) begin
      count_d  = preset_value;
      reload_d = preset_value;
      state_d  = (preset_value != '0) ? RUN : IDLE;
    end else if (abort) begin
      count_d = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN, HOLD: begin
          if (pause) begin
            state_d = HOLD;
          end else begin
            state_d = RUN;
            if (tick) begin
              if (count_q > ONE) begin
                count_d = count_q - ONE;
              end else if (count_q == ONE) begin
                done_d = 1'b1;
                if (auto_reload) begin
                  count_d = reload_q;
                end else begin
                  count_d = '0;
                  state_d = IDLE;
                end
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: begin
          count_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count_out = count_q;
  assign active    = (count_q != '0);
  assign done      = done_q;
  assign paused    = (state_q == HOLD);
  assign state_dbg = state_q;

endmodule
